imem_fetch: RTL and testbench

Parametrised instruction memory with a valid/ready fetch port, registered synchronous read, byte-addressed PC input, range/alignment checking, pipeline flush and a bootloader write port. It sits between the fetch-stage PC logic and the decode stage of the MIPS core and replaces the bare word-indexed instruction ROM. Throughput is one instruction per cycle under no backpressure, with one cycle of latency.

---
 rtl/imem_fetch_if.sv | 28 ++
 rtl/imem_fetch.sv | 85 ++++++++
 tb/tb_imem_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Fetch-port bundle between the PC logic (master) and the instruction memory (slave).
// Also carries the branch-redirect flush and the bootloader write port.
interface imem_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_inst;
    logic [1:0]        resp_err;
    logic              flush;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    modport master (
        output req_valid, req_addr, resp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, resp_valid, resp_inst, resp_err
    );
endinterface

// File: rtl/imem_fetch.sv
// Instruction memory with registered synchronous read behind a valid/ready fetch port.
// Byte-addressed PC, alignment/range checking, flush of the held response, bootloader writes.
module imem_fetch #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    imem_fetch_if.slave bus,
    output logic [31:0] fetch_cnt
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    // Misalignment is reported ahead of out-of-range.
    function automatic logic [1:0] addr_err(input logic [ADDR_W-1:0] addr);
        if (addr[OFF_W-1:0] != '0)
            return ERR_ALIGN;
        if (addr[ADDR_W-1:OFF_W] >= DEPTH_W)
            return ERR_RANGE;
        return ERR_OK;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept_p0;
    logic [1:0]        req_err_p0;
    logic [IDX_W-1:0]  req_idx_p0;
    logic              ld_we_p0;
    logic [IDX_W-1:0]  ld_idx_p0;

    // ---- p0: request/load decode (combinational) ----
    always_comb begin
        req_err_p0 = addr_err(bus.req_addr);
        req_idx_p0 = word_idx(bus.req_addr);
        ld_idx_p0  = word_idx(bus.ld_addr);
        ld_we_p0   = bus.ld_en && (addr_err(bus.ld_addr) == ERR_OK);
    end

    // A load blocks the fetch port so the RAM never sees a read and a write together.
    assign bus.req_ready = !bus.ld_en && (!bus.resp_valid || bus.resp_ready || bus.flush);
    assign accept_p0     = bus.req_valid && bus.req_ready;

    // ---- p1: RAM write (no write while reset is held) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
        end else if (ld_we_p0) begin
            mem[ld_idx_p0] <= bus.ld_data;
        end
    end

    // ---- p1: registered read into the response register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= ERR_OK;
            bus.resp_inst  <= '0;
        end else if (accept_p0) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= req_err_p0;
            bus.resp_inst  <= (req_err_p0 == ERR_OK) ? mem[req_idx_p0] : '0;
        end else if (bus.resp_ready || bus.flush) begin
            bus.resp_valid <= 1'b0;
        end
    end

    // A response taken in the same cycle as a flush still counts as completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_cnt <= '0;
        else if (bus.resp_valid && bus.resp_ready)
            fetch_cnt <= fetch_cnt + 32'd1;
    end
endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: expected responses are queued as requests are accepted.
module tb_imem_fetch;
    typedef struct packed {
        logic [31:0] inst;
        logic [1:0]  err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_cnt;
    int          checks;
    int          errors;
    exp_t        sb [$];
    logic [31:0] model [1024];

    imem_fetch_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    imem_fetch #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fetch_cnt (fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t expect_of(input logic [31:0] a);
        exp_t e;
        if (a[1:0] != 2'b00) begin
            e.inst = 32'h0; e.err = 2'b01;
        end else if (a[31:2] >= 30'd1024) begin
            e.inst = 32'h0; e.err = 2'b10;
        end else begin
            e.inst = model[a[11:2]]; e.err = 2'b00;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] d);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        if (a[1:0] == 2'b00 && a[31:2] < 30'd1024) model[a[11:2]] = d;
        tick();
        bus.ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 0; bus.req_addr = 0; bus.resp_ready = 0; bus.flush = 0;
        bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;
        tick();
        checks++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_inst, fetch_cnt} !== 67'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b e=%b i=%h c=%0d want all zero",
                     bus.resp_valid, bus.resp_err, bus.resp_inst, fetch_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] cnt0;
        exp_t e;
        ld(32'd0, 32'h11111111);
        ld(32'd4, 32'h22222222);
        ld(32'd8, 32'h33333333);
        ld(32'd12, 32'h44444444);
        cnt0 = fetch_cnt;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stream_resp: scoreboard empty");
                end else begin
                    e = sb.pop_front();
                    if ({bus.resp_valid, bus.resp_inst, bus.resp_err} !== {1'b1, e.inst, e.err}) begin
                        errors++;
                        $display("FAIL stream_resp%0d: got v=%b i=%h e=%b want v=1 i=%h e=%b",
                                 i, bus.resp_valid, bus.resp_inst, bus.resp_err, e.inst, e.err);
                    end
                end
            end
            if (i < 4) begin
                bus.req_valid = 1'b1; bus.req_addr = 32'(i * 4);
                #1;
                checks++;
                if (bus.req_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_ready%0d: got %b want 1", i, bus.req_ready);
                end
                sb.push_back(expect_of(bus.req_addr));
            end else begin
                bus.req_valid = 1'b0;
            end
            tick();
        end
        checks++;
        if (bus.resp_valid !== 1'b0 || fetch_cnt !== cnt0 + 32'd4) begin
            errors++;
            $display("FAIL stream_end: got v=%b cnt=%0d want v=0 cnt=%0d", bus.resp_valid, fetch_cnt, cnt0 + 32'd4);
        end
    endtask

    task automatic test_stall();
        logic [31:0] cnt0;
        exp_t e;
        cnt0 = fetch_cnt;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'd4;
        sb.push_back(expect_of(32'd4));
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            checks++;
            if ({bus.resp_valid, bus.resp_inst, bus.req_ready} !== {1'b1, 32'h22222222, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b i=%h rdy=%b want v=1 i=22222222 rdy=0",
                         k, bus.resp_valid, bus.resp_inst, bus.req_ready);
            end
        end
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %b want 1", bus.req_ready);
        end
        e = sb.pop_front();
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0 || fetch_cnt !== cnt0 + 32'd1 || e.inst !== 32'h22222222) begin
            errors++;
            $display("FAIL stall_complete: got v=%b cnt=%0d want v=0 cnt=%0d", bus.resp_valid, fetch_cnt, cnt0 + 32'd1);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [7];
        exp_t e;
        addrs = '{32'h6, 32'h1000, 32'h1002, 32'h0, 32'h4, 32'h8, 32'hC};
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                ld(32'h1000, 32'hBADC0DE5);
                ld(32'h6, 32'hBADC0DE6);
            end
            bus.req_valid = 1'b1; bus.req_addr = addrs[i];
            sb.push_back(expect_of(addrs[i]));
            tick();
            bus.req_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({bus.resp_valid, bus.resp_inst, bus.resp_err} !== {1'b1, e.inst, e.err}) begin
                errors++;
                $display("FAIL err_addr_%h: got v=%b i=%h e=%b want v=1 i=%h e=%b",
                         addrs[i], bus.resp_valid, bus.resp_inst, bus.resp_err, e.inst, e.err);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [31:0] cnt0;
        exp_t e;
        cnt0 = fetch_cnt;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'd4;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.resp_valid, bus.resp_inst} !== {1'b1, 32'h22222222}) begin
            errors++; $display("FAIL flush_held: got v=%b i=%h want v=1 i=22222222", bus.resp_valid, bus.resp_inst);
        end
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'd8;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got %b want 1", bus.req_ready);
        end
        sb.push_back(expect_of(32'd8));
        tick();
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({bus.resp_valid, bus.resp_inst, bus.resp_err, fetch_cnt} !== {1'b1, e.inst, e.err, cnt0}) begin
            errors++;
            $display("FAIL flush_new_resp: got v=%b i=%h cnt=%0d want v=1 i=%h cnt=%0d",
                     bus.resp_valid, bus.resp_inst, fetch_cnt, e.inst, cnt0);
        end
        bus.resp_ready = 1'b1;
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0 || fetch_cnt !== cnt0 + 32'd1) begin
            errors++; $display("FAIL flush_drain: got v=%b cnt=%0d want v=0 cnt=%0d", bus.resp_valid, fetch_cnt, cnt0 + 32'd1);
        end
        bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_addr = 32'd12;
        tick();
        bus.req_valid = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || fetch_cnt !== cnt0 + 32'd1) begin
            errors++; $display("FAIL flush_alone: got v=%b cnt=%0d want v=0 cnt=%0d", bus.resp_valid, fetch_cnt, cnt0 + 32'd1);
        end
        bus.resp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'd0;
        sb.push_back(expect_of(32'd0));
        tick();
        bus.req_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({bus.resp_valid, bus.resp_inst} !== {1'b1, e.inst}) begin
            errors++; $display("FAIL flush_ready_resp: got v=%b i=%h want v=1 i=%h", bus.resp_valid, bus.resp_inst, e.inst);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || fetch_cnt !== cnt0 + 32'd2) begin
            errors++; $display("FAIL flush_with_ready_cnt: got v=%b cnt=%0d want v=0 cnt=%0d", bus.resp_valid, fetch_cnt, cnt0 + 32'd2);
        end
    endtask

    task automatic test_load_priority();
        exp_t e;
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_addr = 32'd0;
        bus.ld_en = 1'b1; bus.ld_addr = 32'd0; bus.ld_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL ld_blocks_ready: got %b want 0", bus.req_ready);
        end
        model[0] = 32'hDEADBEEF;
        tick();
        bus.ld_en = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL ld_no_accept: got v=%b want 0", bus.resp_valid);
        end
        sb.push_back(expect_of(32'd0));
        tick();
        bus.req_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({bus.resp_valid, bus.resp_inst, bus.resp_err} !== {1'b1, e.inst, e.err} || e.inst !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_after_load: got v=%b i=%h want v=1 i=deadbeef", bus.resp_valid, bus.resp_inst);
        end
        tick();
    endtask

    task automatic test_async_reset();
        exp_t e;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'd1002;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.resp_valid, bus.resp_err} !== {1'b1, 2'b01}) begin
            errors++; $display("FAIL pre_reset_full: got v=%b e=%b want v=1 e=01", bus.resp_valid, bus.resp_err);
        end
        bus.req_valid = 1'b1; bus.req_addr = 32'd8;
        bus.resp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_inst, fetch_cnt} !== 67'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b e=%b i=%h c=%0d want all zero",
                     bus.resp_valid, bus.resp_err, bus.resp_inst, fetch_cnt);
        end
        bus.ld_en = 1'b1; bus.ld_addr = 32'd4; bus.ld_data = 32'h55555555;
        tick();
        bus.ld_en = 1'b0;
        rst = 1'b0;
        bus.resp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'd4;
        sb.push_back(expect_of(32'd4));
        tick();
        bus.req_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({bus.resp_valid, bus.resp_inst, bus.resp_err} !== {1'b1, e.inst, e.err}) begin
            errors++;
            $display("FAIL post_reset_fetch: got v=%b i=%h e=%b want v=1 i=%h e=%b",
                     bus.resp_valid, bus.resp_inst, bus.resp_err, e.inst, e.err);
        end
        tick();
        checks++;
        if (fetch_cnt !== 32'd1) begin
            errors++; $display("FAIL post_reset_cnt: got %0d want 1", fetch_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_stall();
        test_errors();
        test_flush();
        test_load_priority();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
